pwm_breathe_sequencer: RTL and testbench



---
 rtl/pwm_breathe_sequencer_if.sv | 31 +++
 rtl/pwm_breathe_sequencer.sv | 149 ++++++++++++++
 tb/tb_pwm_breathe_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_breathe_sequencer_if.sv
// Control/status bundle between software-facing logic and the breathe
// envelope sequencer. The master side drives requests and configuration;
// the sequencer (slave side) returns the duty value and status.
interface pwm_breathe_sequencer_if #(
  parameter int DUTY_W = 6,
  parameter int HOLD_W = 4,
  parameter int RATE_W = 4
);
  logic              period_tick;
  logic              start;
  logic              stop;
  logic              cont;
  logic [DUTY_W-1:0] peak;
  logic [RATE_W-1:0] rate;
  logic [HOLD_W-1:0] hold;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              busy;
  logic [2:0]        state;
  logic              done;

  modport master (
    output period_tick, start, stop, cont, peak, rate, hold,
    input  duty, duty_valid, busy, state, done
  );

  modport slave (
    input  period_tick, start, stop, cont, peak, rate, hold,
    output duty, duty_valid, busy, state, done
  );
endinterface

// File: rtl/pwm_breathe_sequencer.sv
// Breathe envelope sequencer: walks the PWM duty value through
// rise -> hold high -> fall -> hold low, advancing only on PWM period
// boundaries so the comparator never sees a mid-period duty change.
// Configuration is captured when a start is accepted; later changes on the
// inputs are ignored until the next start.
module pwm_breathe_sequencer #(
  parameter int DUTY_W = 6,
  parameter int HOLD_W = 4,
  parameter int RATE_W = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  pwm_breathe_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISE    = 3'd1,
    S_HOLD_HI = 3'd2,
    S_FALL    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_e;

  state_e            state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] peak_q;
  logic [RATE_W-1:0] rate_q;
  logic [HOLD_W-1:0] hold_q;
  logic              cont_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [RATE_W-1:0] presc_q;
  logic [RATE_W-1:0] presc_d;
  logic              duty_valid_q;
  logic              done_q;
  logic              accept_s;
  logic              step_s;

  // A start request is honoured only while idle; elsewhere it is ignored.
  assign accept_s = (state_q == S_IDLE) && bus.start;
  // One envelope step every rate+1 PWM periods.
  assign step_s   = bus.period_tick && (presc_q == rate_q);

  // Prescaler next value: cleared on start or step, counts period ticks otherwise.
  always_comb begin
    presc_d = presc_q;
    if (accept_s) begin
      presc_d = '0;
    end else if (step_s) begin
      presc_d = '0;
    end else if (bus.period_tick) begin
      presc_d = presc_q + RATE_W'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Envelope FSM with registered duty, duty_valid and done outputs.
  // Compares happen before inc/dec, so duty never wraps at 0 or at peak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      duty_q       <= '0;
      peak_q       <= '0;
      rate_q       <= '0;
      hold_q       <= '0;
      cont_q       <= 1'b0;
      hold_cnt_q   <= '0;
      presc_q      <= '0;
      duty_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      duty_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (accept_s) begin
        // start wins over a simultaneous stop while idle
        peak_q       <= bus.peak;
        rate_q       <= bus.rate;
        hold_q       <= bus.hold;
        cont_q       <= bus.cont;
        duty_q       <= '0;
        duty_valid_q <= (duty_q != '0);
        hold_cnt_q   <= '0;
        state_q      <= S_RISE;
      end else if ((state_q != S_IDLE) && bus.stop) begin
        // abort takes priority over any step in the same cycle
        duty_q       <= '0;
        duty_valid_q <= (duty_q != '0);
        done_q       <= 1'b1;
        state_q      <= S_IDLE;
      end else if (step_s) begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_RISE: begin
            if (duty_q == peak_q) begin
              hold_cnt_q <= '0;
              state_q    <= S_HOLD_HI;
            end else begin
              duty_q       <= duty_q + DUTY_W'(1);
              duty_valid_q <= 1'b1;
            end
          end
          S_HOLD_HI: begin
            if (hold_cnt_q == hold_q) begin
              state_q <= S_FALL;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          S_FALL: begin
            if (duty_q == '0) begin
              hold_cnt_q <= '0;
              state_q    <= S_HOLD_LO;
            end else begin
              duty_q       <= duty_q - DUTY_W'(1);
              duty_valid_q <= 1'b1;
            end
          end
          S_HOLD_LO: begin
            if (hold_cnt_q == hold_q) begin
              if (cont_q) begin
                state_q <= S_RISE;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          default: begin
            // unreachable encodings recover to idle
            duty_q  <= '0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.state      = state_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_pwm_breathe_sequencer.sv
// Scoreboard bench for pwm_breathe_sequencer: a behavioural envelope model
// pushes the expected outputs when each cycle's stimulus is driven, and they
// are popped and compared one time unit after the clock edge.
module tb_pwm_breathe_sequencer;
  localparam int DUTY_W = 6;
  localparam int HOLD_W = 4;
  localparam int RATE_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // 10 time-unit clock
  always #5 clk = ~clk;

  pwm_breathe_sequencer_if #(.DUTY_W(DUTY_W), .HOLD_W(HOLD_W), .RATE_W(RATE_W)) bus ();

  pwm_breathe_sequencer #(.DUTY_W(DUTY_W), .HOLD_W(HOLD_W), .RATE_W(RATE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [5:0] duty;
    logic       dv;
    logic       busy;
    logic [2:0] state;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ticks = 0;
  int   done_cyc = -1;
  int   done_tick = -1;
  int   s_cyc = 0;
  int   s_tick = 0;
  bit   gaps = 1'b0;
  int   dv_duty[$];
  int   dv_tick[$];

  // reference model state
  int m_state, m_duty, m_presc, m_hcnt, m_peak, m_rate, m_hold;
  bit m_cont;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_duty = 0; m_presc = 0; m_hcnt = 0;
    m_peak = 0; m_rate = 0; m_hold = 0; m_cont = 1'b0;
  endtask

  task automatic model_next(output exp_t e);
    bit tk, stp;
    tk  = bus.period_tick;
    stp = tk && (m_presc == m_rate);
    e   = '0;
    if (m_state == 0 && bus.start) begin
      m_peak = int'(bus.peak); m_rate = int'(bus.rate);
      m_hold = int'(bus.hold); m_cont = bus.cont;
      m_presc = 0; m_hcnt = 0; m_duty = 0; m_state = 1;
    end else begin
      if (stp) m_presc = 0;
      else if (tk) m_presc = m_presc + 1;
      if (m_state != 0 && bus.stop) begin
        e.dv = (m_duty != 0); e.done = 1'b1; m_duty = 0; m_state = 0;
      end else if (stp) begin
        case (m_state)
          1: if (m_duty == m_peak) begin m_state = 2; m_hcnt = 0; end
             else begin m_duty = m_duty + 1; e.dv = 1'b1; end
          2: if (m_hcnt == m_hold) m_state = 3; else m_hcnt = m_hcnt + 1;
          3: if (m_duty == 0) begin m_state = 4; m_hcnt = 0; end
             else begin m_duty = m_duty - 1; e.dv = 1'b1; end
          4: if (m_hcnt == m_hold) begin
               if (m_cont) m_state = 1;
               else begin m_state = 0; e.done = 1'b1; end
             end else m_hcnt = m_hcnt + 1;
          default: m_state = 0;
        endcase
      end
    end
    e.duty  = 6'(m_duty);
    e.busy  = (m_state != 0);
    e.state = 3'(m_state);
  endtask

  // one clock: drive tick, predict, advance, compare
  task automatic cycle();
    exp_t e;
    bus.period_tick = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    model_next(e);
    exp_q.push_back(e);
    if (bus.period_tick) ticks++;
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    chk("duty",       32'(bus.duty),       32'(e.duty));
    chk("duty_valid", 32'(bus.duty_valid), 32'(e.dv));
    chk("busy",       32'(bus.busy),       32'(e.busy));
    chk("state",      32'(bus.state),      32'(e.state));
    chk("done",       32'(bus.done),       32'(e.done));
    if (bus.duty_valid) begin
      dv_duty.push_back(int'(bus.duty));
      dv_tick.push_back(ticks);
    end
    if (bus.done) begin
      done_cyc  = cyc;
      done_tick = ticks;
    end
  endtask

  task automatic start_env(input int pk, input int rt, input int hd, input bit ct);
    bus.peak = 6'(pk); bus.rate = 4'(rt); bus.hold = 4'(hd); bus.cont = ct;
    dv_duty.delete(); dv_tick.delete();
    done_cyc = -1; done_tick = -1;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    s_cyc  = cyc;
    s_tick = ticks;
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && done_cyc < 0; i++) cycle();
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_state(input int s, input int budget);
    for (int i = 0; i < budget && int'(bus.state) != s; i++) cycle();
    chk("wait_state", 32'(bus.state), 32'(s));
  endtask

  int steps1[6] = '{1, 2, 3, 7, 8, 9};
  int seq1[6]   = '{1, 2, 3, 2, 1, 0};
  int mx;

  initial begin
    bus.period_tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
    bus.peak = '0; bus.rate = '0; bus.hold = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_duty",  32'(bus.duty),       32'd0);
    chk("rst_dv",    32'(bus.duty_valid), 32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    chk("rst_state", 32'(bus.state),      32'd0);
    chk("rst_done",  32'(bus.done),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // single breath, with an ignored restart attempt while busy
    start_env(3, 0, 1, 1'b0);
    cycle(); cycle();
    bus.start = 1'b1; bus.peak = 6'd10; bus.hold = 4'd5;
    cycle();
    bus.start = 1'b0;
    run_to_done(40);
    chk("t1_latency", 32'(done_cyc - s_cyc), 32'd12);
    chk("t1_nchg", 32'(dv_duty.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_seq%0d", i), (i < dv_duty.size()) ? 32'(dv_duty[i]) : 32'hffff_ffff, 32'(seq1[i]));
      chk($sformatf("t1_when%0d", i), (i < dv_tick.size()) ? 32'(dv_tick[i] - s_tick) : 32'hffff_ffff, 32'(steps1[i]));
    end
    chk("t1_busy_end", 32'(bus.busy), 32'd0);
    chk("t1_state_end", 32'(bus.state), 32'd0);
    cycle();

    // prescaler, steady ticks then gappy ticks
    for (int g = 0; g < 2; g++) begin
      gaps = (g == 1);
      start_env(3, 2, 1, 1'b0);
      run_to_done(300);
      chk($sformatf("t2_ticks_g%0d", g), 32'(done_tick - s_tick), 32'd36);
      chk($sformatf("t2_nchg_g%0d", g), 32'(dv_duty.size()), 32'd6);
      for (int i = 0; i < 6; i++)
        chk($sformatf("t2_when%0d_g%0d", i, g), (i < dv_tick.size()) ? 32'(dv_tick[i] - s_tick) : 32'hffff_ffff, 32'(3 * steps1[i]));
      cycle();
    end
    gaps = 1'b0;

    // continuous mode, then stop in HOLD_HI
    start_env(2, 0, 0, 1'b1);
    wait_state(4, 50);
    cycle();
    chk("t3_rerise", 32'(bus.state), 32'd1);
    chk("t3_nodone", 32'(bus.done), 32'd0);
    wait_state(2, 50);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    chk("t3_stop_state", 32'(bus.state), 32'd0);
    chk("t3_stop_duty", 32'(bus.duty), 32'd0);
    chk("t3_stop_done", 32'(bus.done), 32'd1);
    chk("t3_stop_dv", 32'(bus.duty_valid), 32'd1);
    cycle();

    // peak = 0
    start_env(0, 0, 2, 1'b0);
    run_to_done(50);
    chk("t4_nchg", 32'(dv_duty.size()), 32'd0);
    chk("t4_latency", 32'(done_cyc - s_cyc), 32'd8);

    // peak = 63, hold = 15
    start_env(63, 0, 15, 1'b0);
    run_to_done(300);
    mx = 0;
    foreach (dv_duty[i]) if (dv_duty[i] > mx) mx = dv_duty[i];
    chk("t5_max", 32'(mx), 32'd63);
    chk("t5_nchg", 32'(dv_duty.size()), 32'd126);
    chk("t5_latency", 32'(done_cyc - s_cyc), 32'd160);

    // asynchronous reset mid-FALL
    start_env(5, 0, 0, 1'b0);
    wait_state(3, 50);
    cycle(); cycle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_duty",  32'(bus.duty),       32'd0);
    chk("t6_state", 32'(bus.state),      32'd0);
    chk("t6_busy",  32'(bus.busy),       32'd0);
    chk("t6_done",  32'(bus.done),       32'd0);
    chk("t6_dv",    32'(bus.duty_valid), 32'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();

    // start and stop together while idle: start wins
    bus.stop = 1'b1;
    start_env(2, 0, 0, 1'b0);
    chk("t7_state", 32'(bus.state), 32'd1);
    chk("t7_busy", 32'(bus.busy), 32'd1);
    cycle();
    chk("t7_stopped", 32'(bus.state), 32'd0);
    bus.stop = 1'b0;
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
